// File: rtl/regfile_arb_pkg.sv
// Shared types for the register-file write arbiter.
//   REG_IDX_W / DATA_W : register index and data widths of the regfile write port
//   arb_state_t        : arbiter state (IDLE, PENDING, STALL)
//   game_wr_t          : one buffered game write (target register + data)
//   reg_in_range       : true when a register index lies in [lo, hi]
package regfile_arb_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    STALL   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [REG_IDX_W-1:0] wreg;
    logic [DATA_W-1:0]    wdata;
  } game_wr_t;

  function automatic logic reg_in_range(input logic [REG_IDX_W-1:0] idx,
                                        input int lo, input int hi);
    return (int'(idx) >= lo) && (int'(idx) <= hi);
  endfunction

endpackage

// File: rtl/game_write_fifo.sv
// Synchronous FIFO holding pending game register writes.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset (clears pointers and count)
//   push       : store push_data (ignored when full)
//   push_data  : entry to store
//   pop        : drop the head entry (ignored when empty)
//   head       : oldest stored entry, valid while count != 0
//   count      : number of occupied entries
module game_write_fifo
  import regfile_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 push,
  input  game_wr_t                             push_data,
  input  logic                                 pop,
  output game_wr_t                             head,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  game_wr_t          r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign w_do_push = push && (r_count != CNT_W'(FIFO_DEPTH));
  assign w_do_pop  = pop && (r_count != '0);

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between CPU writeback and game logic.
// CPU writes pass straight through; game writes are queued and issued in idle write
// cycles. A starvation timer forces a one-cycle CPU stall so a queued write drains.
//   clock / ctrl_reset          : clock and asynchronous active-high reset
//   cpu_we/cpu_wreg/cpu_wdata   : CPU writeback request
//   game_valid/game_ready       : game request handshake
//   game_wreg/game_wdata        : game request target and data
//   game_err                    : pulse, an accepted game request was out of range and dropped
//   cpu_stall                   : pipeline freeze for one cycle while a game write drains
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg : regfile write port
//   fifo_count                  : occupied game FIFO entries
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int GAME_REG_LO  = 24,
  parameter int GAME_REG_HI  = 29
) (
  input  logic                                clock,
  input  logic                                ctrl_reset,
  input  logic                                cpu_we,
  input  logic [REG_IDX_W-1:0]                cpu_wreg,
  input  logic [DATA_W-1:0]                   cpu_wdata,
  input  logic                                game_valid,
  output logic                                game_ready,
  input  logic [REG_IDX_W-1:0]                game_wreg,
  input  logic [DATA_W-1:0]                   game_wdata,
  output logic                                game_err,
  output logic                                cpu_stall,
  output logic                                ctrl_writeEnable,
  output logic [REG_IDX_W-1:0]                ctrl_writeReg,
  output logic [DATA_W-1:0]                   data_writeReg,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);

  localparam int CNT_W    = $clog2(FIFO_DEPTH+1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT) + 1;

  arb_state_t          r_state;
  logic [STARVE_W-1:0] r_starve;
  logic                r_game_err;

  logic                w_accept;
  logic                w_in_range;
  logic                w_push;
  logic                w_pop;
  logic [CNT_W-1:0]    w_count;
  logic [CNT_W-1:0]    w_cnt_next;
  game_wr_t            w_head;
  game_wr_t            w_push_data;

  // Readiness depends on the registered count only, so a full FIFO refuses a push
  // even in a cycle where the head drains.
  assign game_ready  = !ctrl_reset && (w_count < CNT_W'(FIFO_DEPTH));
  assign w_accept    = game_valid && game_ready;
  assign w_in_range  = reg_in_range(game_wreg, GAME_REG_LO, GAME_REG_HI);
  assign w_push      = w_accept && w_in_range;
  assign w_push_data = '{wreg: game_wreg, wdata: game_wdata};

  game_write_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clock),
    .rst       (ctrl_reset),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count)
  );

  assign w_cnt_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // Port select. A CPU write to r0 is treated as idle so the FIFO can drain.
  // In STALL the CPU is frozen and will re-present its writeback next cycle.
  always_comb begin
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    data_writeReg    = '0;
    w_pop            = 1'b0;
    if (ctrl_reset) begin
      ctrl_writeEnable = 1'b0;
    end else if (r_state == STALL) begin
      if (w_count != '0) begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = w_head.wreg;
        data_writeReg    = w_head.wdata;
        w_pop            = 1'b1;
      end
    end else if (cpu_we && (cpu_wreg != '0)) begin
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = cpu_wreg;
      data_writeReg    = cpu_wdata;
    end else if (w_count != '0) begin
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = w_head.wreg;
      data_writeReg    = w_head.wdata;
      w_pop            = 1'b1;
    end
  end

  // Arbiter state and starvation timer. The timer counts cycles in which queued
  // entries wait without a game issue; reaching STARVE_LIMIT-1 forces STALL.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      r_state    <= IDLE;
      r_starve   <= '0;
      r_game_err <= 1'b0;
    end else begin
      r_game_err <= w_accept && !w_in_range;
      case (r_state)
        IDLE: begin
          r_starve <= '0;
          if (w_push) begin
            r_state <= PENDING;
          end
        end
        PENDING: begin
          if (w_pop) begin
            r_starve <= '0;
            if (w_cnt_next == '0) begin
              r_state <= IDLE;
            end
          end else if (r_starve == STARVE_W'(STARVE_LIMIT - 1)) begin
            r_starve <= '0;
            r_state  <= STALL;
          end else begin
            r_starve <= r_starve + 1'b1;
          end
        end
        STALL: begin
          r_starve <= '0;
          r_state  <= (w_cnt_next == '0) ? IDLE : PENDING;
        end
        default: begin
          r_starve <= '0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign cpu_stall  = (r_state == STALL);
  assign game_err   = r_game_err;
  assign fifo_count = w_count;

endmodule
